// File: rtl/edge_event_arbiter.sv
// Synchronizes asynchronous request lines, turns rising edges into pending events and offers them round-robin.
// Define EDGE_EVENT_ARBITER_DEBOUNCE_EN to compile in a per-channel stable-sample debounce filter.
module edge_event_arbiter #(
    parameter int channelCount   = 4,
    parameter int stageCount     = 2,
    parameter int debounceCycles = 8
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [channelCount-1:0]         requestIn,
    output logic                            eventValid,
    output logic [$clog2(channelCount)-1:0] eventChannel,
    output logic                            eventOverflow,
    input  logic                            eventAck,
    output logic [channelCount-1:0]         pendingOut
);

    localparam int chanW = $clog2(channelCount);

    typedef enum logic {IDLE, OFFER} state_t;

    logic [channelCount-1:0][stageCount-1:0] syncChain_q;
    logic [channelCount-1:0]                 syncLevel;
    logic [channelCount-1:0]                 detectLevel;
    logic [channelCount-1:0]                 prevLevel_q;
    logic [channelCount-1:0]                 edgeHit;
    logic [channelCount-1:0]                 pending_q, pending_d;
    logic [channelCount-1:0]                 overflow_q, overflow_d;
    state_t                                  state_q, state_d;
    logic [chanW-1:0]                        lastGrant_q, lastGrant_d;
    logic [chanW-1:0]                        offerChannel_q, offerChannel_d;
    logic                                    offerOverflow_q, offerOverflow_d;
    logic [chanW-1:0]                        candidate;
    logic [chanW-1:0]                        grantIndex;
    logic                                    grantFound;
    logic                                    ackFire;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            syncChain_q <= '0;
        end else begin
            for (int ch = 0; ch < channelCount; ch++) begin
                syncChain_q[ch] <= {syncChain_q[ch][stageCount-2:0], requestIn[ch]};
            end
        end
    end

    always_comb begin
        syncLevel = '0;
        for (int ch = 0; ch < channelCount; ch++) begin
            syncLevel[ch] = syncChain_q[ch][stageCount-1];
        end
    end

`ifdef EDGE_EVENT_ARBITER_DEBOUNCE_EN
    logic [channelCount-1:0]      filtered_q;
    logic [channelCount-1:0][7:0] debounceCount_q;

    // The filtered level only follows the synchronized level after it has differed for debounceCycles samples.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            filtered_q      <= '0;
            debounceCount_q <= '0;
        end else begin
            for (int ch = 0; ch < channelCount; ch++) begin
                if (syncLevel[ch] == filtered_q[ch]) begin
                    debounceCount_q[ch] <= 8'd0;
                end else if (debounceCount_q[ch] == 8'(debounceCycles - 1)) begin
                    filtered_q[ch]      <= syncLevel[ch];
                    debounceCount_q[ch] <= 8'd0;
                end else begin
                    debounceCount_q[ch] <= debounceCount_q[ch] + 8'd1;
                end
            end
        end
    end

    assign detectLevel = filtered_q;
`else
    assign detectLevel = syncLevel;
`endif

    assign edgeHit = detectLevel & ~prevLevel_q;
    assign ackFire = (state_q == OFFER) && eventAck;

    // An edge arriving with the acknowledge of its own channel is a fresh event, so pending survives but overflow does not.
    always_comb begin
        pending_d  = pending_q;
        overflow_d = overflow_q;
        for (int ch = 0; ch < channelCount; ch++) begin
            if (ackFire && (offerChannel_q == chanW'(ch))) begin
                pending_d[ch]  = edgeHit[ch];
                overflow_d[ch] = 1'b0;
            end else if (edgeHit[ch]) begin
                pending_d[ch]  = 1'b1;
                overflow_d[ch] = overflow_q[ch] | pending_q[ch];
            end
        end
    end

    always_comb begin
        grantFound = 1'b0;
        grantIndex = '0;
        candidate  = '0;
        for (int i = 1; i <= channelCount; i++) begin
            candidate = chanW'((int'(lastGrant_q) + i) % channelCount);
            if (!grantFound && pending_q[candidate]) begin
                grantFound = 1'b1;
                grantIndex = candidate;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (|pending_q) state_d = OFFER;
            OFFER:   if (eventAck)   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        eventValid = (state_q == OFFER);
    end

    always_comb begin
        offerChannel_d  = offerChannel_q;
        offerOverflow_d = offerOverflow_q;
        lastGrant_d     = lastGrant_q;
        if (state_q == IDLE && grantFound) begin
            offerChannel_d  = grantIndex;
            offerOverflow_d = overflow_q[grantIndex];
        end
        if (ackFire) begin
            lastGrant_d = offerChannel_q;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            prevLevel_q     <= '0;
            pending_q       <= '0;
            overflow_q      <= '0;
            lastGrant_q     <= chanW'(channelCount - 1);
            offerChannel_q  <= '0;
            offerOverflow_q <= 1'b0;
        end else begin
            prevLevel_q     <= detectLevel;
            pending_q       <= pending_d;
            overflow_q      <= overflow_d;
            lastGrant_q     <= lastGrant_d;
            offerChannel_q  <= offerChannel_d;
            offerOverflow_q <= offerOverflow_d;
        end
    end

    assign eventChannel  = offerChannel_q;
    assign eventOverflow = offerOverflow_q;
    assign pendingOut    = pending_q;

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Self-checking bench for edge_event_arbiter: vector table of request patterns with a scoreboard of expected
// offers, plus hand-written latency, overflow, ack-cycle-edge and reset sequences.
module tb_edge_event_arbiter;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] requestIn = 4'b0000;
    logic       eventAck = 1'b0;
    logic       eventValid;
    logic [1:0] eventChannel;
    logic       eventOverflow;
    logic [3:0] pendingOut;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [1:0] ch;
        logic       ovf;
    } evT;

    typedef struct {
        logic [3:0]  req;
        logic [15:0] order;
        int          n;
    } vecT;

    evT  expQ[$];
    vecT vecs[7];

    edge_event_arbiter #(
        .channelCount(4),
        .stageCount(2),
        .debounceCycles(8)
    ) dut (
        .clock(clock),
        .reset(reset),
        .requestIn(requestIn),
        .eventValid(eventValid),
        .eventChannel(eventChannel),
        .eventOverflow(eventOverflow),
        .eventAck(eventAck),
        .pendingOut(pendingOut)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] value);
        requestIn = value;
    endtask

    task automatic applyReset();
        @(negedge clock);
        reset    = 1'b0;
        eventAck = 1'b0;
        expQ.delete();
        repeat (3) @(negedge clock);
        checkOutput("resetValid", eventValid, 0);
        checkOutput("resetChannel", eventChannel, 0);
        checkOutput("resetOverflow", eventOverflow, 0);
        checkOutput("resetPending", pendingOut, 0);
        reset = 1'b1;
    endtask

    task automatic waitValid(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clock);
            if (eventValid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("[TB] FAIL waitValid: eventValid=0 after %0d cycles, required 1", budget);
        end
    endtask

    task automatic popCompare();
        evT e;
        e = expQ.pop_front();
        checkOutput("eventChannel", eventChannel, e.ch);
        checkOutput("eventOverflow", eventOverflow, e.ovf);
    endtask

    task automatic drainEvents(input int budget);
        bit ok;
        while (expQ.size() > 0) begin
            waitValid(budget, ok);
            if (!ok) begin
                expQ.delete();
                break;
            end
            popCompare();
            eventAck = 1'b1;
            @(negedge clock);
            eventAck = 1'b0;
            checkOutput("gapAfterAck", eventValid, 0);
        end
    endtask

    task automatic checkQuiet(input int cycles);
        logic sawValid;
        sawValid = 1'b0;
        repeat (cycles) begin
            @(negedge clock);
            if (eventValid) sawValid = 1'b1;
        end
        checkOutput("noExtraEvent", sawValid, 0);
    endtask

    initial begin
        vecT        v;
        evT         e;
        logic [3:0] nib;
        bit         ok;

        // order nibbles: first grant in [3:0]; lastGrant carries over from one entry to the next
        vecs[0] = '{req: 4'b1111, order: 16'h3210, n: 4};
        vecs[1] = '{req: 4'b0110, order: 16'h0021, n: 2};
        vecs[2] = '{req: 4'b1001, order: 16'h0003, n: 2};
        vecs[3] = '{req: 4'b0101, order: 16'h0002, n: 2};
        vecs[4] = '{req: 4'b1010, order: 16'h0031, n: 2};
        vecs[5] = '{req: 4'b0100, order: 16'h0002, n: 1};
        vecs[6] = '{req: 4'b0011, order: 16'h0010, n: 2};

`ifndef EDGE_EVENT_ARBITER_DEBOUNCE_EN
        // Latency from the first sampling edge, then a one-cycle acknowledge
        applyReset();
        applyStimulus(4'b0001);
        repeat (3) @(posedge clock);
        @(negedge clock);
        checkOutput("latencyEdge3Valid", eventValid, 0);
        checkOutput("latencyEdge3Pending", pendingOut, 4'b0001);
        @(posedge clock);
        @(negedge clock);
        checkOutput("latencyEdge4Valid", eventValid, 1);
        checkOutput("latencyEdge4Channel", eventChannel, 0);
        eventAck = 1'b1;
        @(negedge clock);
        eventAck = 1'b0;
        checkOutput("ackPending", pendingOut, 0);
        checkOutput("ackValid", eventValid, 0);
        applyStimulus(4'b0000);
        checkQuiet(10);
`endif

        // Round-robin vector table with immediate acknowledge
        applyReset();
        for (int i = 0; i < 7; i++) begin
            v = vecs[i];
            applyStimulus(v.req);
            for (int k = 0; k < v.n; k++) begin
                nib   = v.order[4*k +: 4];
                e.ch  = nib[1:0];
                e.ovf = 1'b0;
                expQ.push_back(e);
            end
            drainEvents(60);
            checkOutput("vectorPendingClear", pendingOut, 0);
            applyStimulus(4'b0000);
            checkQuiet(25);
        end

`ifndef EDGE_EVENT_ARBITER_DEBOUNCE_EN
        // Two pulses on channel 2 while channel 0 is held in OFFER
        applyReset();
        applyStimulus(4'b0001);
        waitValid(20, ok);
        for (int p = 0; p < 2; p++) begin
            applyStimulus(4'b0101);
            repeat (3) @(negedge clock);
            applyStimulus(4'b0001);
            repeat (3) @(negedge clock);
        end
        repeat (6) @(negedge clock);
        checkOutput("heldValid", eventValid, 1);
        checkOutput("heldChannel", eventChannel, 0);
        checkOutput("heldPending", pendingOut, 4'b0101);
        expQ.push_back('{ch: 2'd0, ovf: 1'b0});
        expQ.push_back('{ch: 2'd2, ovf: 1'b1});
        drainEvents(30);
        applyStimulus(4'b0000);
        checkQuiet(15);

        // Fresh edge on the offered channel in the acknowledge cycle
        applyReset();
        applyStimulus(4'b0010);
        waitValid(20, ok);
        checkOutput("firstOfferChannel", eventChannel, 1);
        applyStimulus(4'b0000);
        repeat (6) @(negedge clock);
        applyStimulus(4'b0010);
        @(negedge clock);
        @(negedge clock);
        eventAck = 1'b1;
        @(negedge clock);
        eventAck = 1'b0;
        checkOutput("ackEdgePending", pendingOut[1], 1);
        checkOutput("ackEdgeValid", eventValid, 0);
        expQ.push_back('{ch: 2'd1, ovf: 1'b0});
        drainEvents(20);
        applyStimulus(4'b0000);
        checkQuiet(15);
`endif

        // Reset in the middle of an offer
        applyReset();
        applyStimulus(4'b0100);
        waitValid(60, ok);
        checkOutput("preResetChannel", eventChannel, 2);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("asyncResetValid", eventValid, 0);
        checkOutput("asyncResetPending", pendingOut, 0);
        applyStimulus(4'b1000);
        @(negedge clock);
        reset = 1'b1;
        expQ.push_back('{ch: 2'd3, ovf: 1'b0});
        drainEvents(60);
        checkQuiet(30);
        applyStimulus(4'b0000);
        checkQuiet(30);

`ifdef EDGE_EVENT_ARBITER_DEBOUNCE_EN
        // Short glitch is filtered, long pulse gives exactly one event
        applyReset();
        applyStimulus(4'b1000);
        repeat (5) @(negedge clock);
        applyStimulus(4'b0000);
        repeat (20) @(negedge clock);
        checkOutput("glitchValid", eventValid, 0);
        checkOutput("glitchPending", pendingOut, 0);
        applyStimulus(4'b1000);
        repeat (11) @(posedge clock);
        @(negedge clock);
        checkOutput("debounceEdge11Valid", eventValid, 0);
        @(posedge clock);
        @(negedge clock);
        checkOutput("debounceEdge12Valid", eventValid, 1);
        checkOutput("debounceChannel", eventChannel, 3);
        eventAck = 1'b1;
        @(negedge clock);
        eventAck = 1'b0;
        repeat (7) @(negedge clock);
        applyStimulus(4'b0000);
        checkQuiet(40);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/edge_event_arbiter.md
EDGE_EVENT_ARBITER -- requirements
Module: edge_event_arbiter

Interface
REQ-001 The block SHALL have parameter channelCount, default 4, number of asynchronous request channels (2..16).
REQ-002 The block SHALL have parameter stageCount, default 2, synchronizer depth per channel (>=2).
REQ-003 The block SHALL have parameter debounceCycles, default 8, stable-sample count used when debouncing is compiled in (2..255).
REQ-004 clock  input  1  system clock; the only clock; all state on its rising edge.
REQ-005 reset  input  1  system reset, asynchronous, active-low.
REQ-006 requestIn  input  channelCount  asynchronous request levels, one per channel.
REQ-007 eventValid  output  1  an event is offered to the consumer.
REQ-008 eventChannel  output  clog2(channelCount)  index of the offered channel.
REQ-009 eventOverflow  output  1  the offered channel saw more than one rising edge since its last acknowledge.
REQ-010 eventAck  input  1  consumer accepts the offered event.
REQ-011 pendingOut  output  channelCount  per-channel pending flags, registered.

Function
REQ-012 Each requestIn bit SHALL pass through its own stageCount-deep shift register; the last stage is the synchronized level.
REQ-013 A rising edge SHALL be detected when the synchronized (or debounced, see REQ-024) level is 1 and its previous-cycle value is 0.
REQ-014 A detected edge SHALL set pending[ch] at the next clock edge.
REQ-015 An edge on a channel already pending SHALL set overflow[ch]; pending stays 1.
REQ-016 Arbiter states: IDLE, OFFER; eventValid is 1 only in OFFER.
REQ-017 IDLE: if any pending bit is 1, SHALL register eventChannel = first pending channel searching round-robin from lastGrant+1 (wrapping), set eventOverflow = overflow[that channel], and enter OFFER; else stay IDLE.
REQ-018 OFFER: eventChannel and eventOverflow SHALL be held stable until eventAck is sampled 1.
REQ-019 On eventAck in OFFER: pending and overflow of the offered channel SHALL clear, lastGrant SHALL take eventChannel, state SHALL return to IDLE (eventValid 0 for at least one cycle).
REQ-020 Edge on the offered channel in the same cycle as eventAck: pending SHALL remain 1, overflow SHALL clear (the new edge is a fresh event).
REQ-021 eventAck while IDLE SHALL be ignored.
REQ-022 Latency, no debounce, arbiter idle, no other pending: eventValid SHALL rise after the (stageCount+2)th clock edge counting the first edge that samples requestIn high (4 edges for stageCount=2).
REQ-023 Falling edges SHALL produce no event.

Reset
REQ-024 While reset is 0: all synchronizer stages, previous-level registers, pending, overflow, debounce state 0; state IDLE; lastGrant = channelCount-1 (so channel 0 wins first); eventValid 0, eventChannel 0, eventOverflow 0, pendingOut 0.
REQ-025 Reset asserted during OFFER SHALL drop eventValid immediately and discard all pending events; inputs already high at reset release SHALL produce one event per channel after synchronization.

Configuration
REQ-026 With macro EDGE_EVENT_ARBITER_DEBOUNCE_EN defined, each channel SHALL have a filtered level and counter: counter 0 when synchronized == filtered; otherwise counter increments, and on reaching debounceCycles-1 filtered takes the synchronized value and counter clears; edge detection uses filtered, adding debounceCycles cycles of latency; glitches shorter than debounceCycles cycles SHALL produce no event.
REQ-027 Without the macro, no filter or counter logic SHALL exist and edge detection uses the synchronized level directly.

Verification
REQ-028 Reset release, requestIn=4'b0001 from edge 1, stageCount=2, no debounce -> eventValid=1, eventChannel=0 after edge 4; eventAck 1 cycle -> pendingOut=0, eventValid=0.
REQ-029 requestIn 4'b0000->4'b1111 in one cycle, ack every offer immediately -> grant order 0,1,2,3, eventValid low one cycle between offers.
REQ-030 Channel 2 pulsed twice (3 cycles high, 3 low) while arbiter held in OFFER on channel 0 -> channel 2 later offered once with eventOverflow=1.
REQ-031 Rising edge on offered channel 1 in the ack cycle -> pendingOut[1] stays 1, channel 1 re-offered with eventOverflow=0.
REQ-032 reset driven 0 mid-OFFER -> eventValid 0 asynchronously, pendingOut 0; no event for lines low at release.
REQ-033 DEBOUNCE_EN, debounceCycles=8: 5-cycle glitch on channel 3 -> no event; 20-cycle high -> exactly one event, eventValid after edge 12.
